pipe_regfile: RTL and testbench
===============================

PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 rd_addr  in  NRD x AW  read addresses.
REQ-009 rd_data  out  NRD x XLEN  read data, combinational.
REQ-010 rd_busy  out  NRD  scoreboard busy bit of each read address, combinational.
REQ-011 wr_en  in  NWR  per-port write enable.
REQ-012 wr_addr  in  NWR x AW  write addresses.
REQ-013 wr_data  in  NWR x XLEN  write data.
REQ-014 alloc_en  in  1  marks alloc_addr as pending write (issue stage).
REQ-015 alloc_addr  in  AW  destination being allocated.
REQ-016 flush  in  1  synchronous clear of all busy bits (pipeline flush).
REQ-017 busy_vec  out  NREG  full scoreboard state, registered.

Function
REQ-018 Register 0 SHALL read as 0, never be written, and never be busy; writes/allocs to 0 are ignored.
REQ-019 Writes SHALL take effect at the rising clk edge when wr_en[p]=1.
REQ-020 Multiple ports writing the same address in one cycle: highest port index SHALL win.
REQ-021 BYPASS=1: rd_data[r] SHALL equal the winning same-cycle wr_data for rd_addr[r] (per REQ-020), else the stored value.
REQ-022 BYPASS=0: rd_data[r] SHALL return the stored value only; new data visible the cycle after the write.
REQ-023 Busy bit SHALL set at the edge where alloc_en=1 for alloc_addr.
REQ-024 Busy bit SHALL clear at the edge where any enabled write port targets that address.
REQ-025 Alloc and write to the same address in one cycle: busy SHALL end set (new producer wins).
REQ-026 flush=1 SHALL clear all busy bits at the edge, overriding alloc_en in that cycle; register data unaffected; writes in that cycle still commit.
REQ-027 rd_busy[r] SHALL reflect busy_vec[rd_addr[r]], cleared combinationally when BYPASS=1 and a same-cycle write targets that address.
REQ-028 Read ports SHALL be fully independent; identical addresses on several ports return identical data.

Reset
REQ-029 rst_n low SHALL asynchronously clear all registers to 0 and busy_vec to 0.
REQ-030 While rst_n low, writes and allocs SHALL be ignored; rd_data returns 0 for all addresses.
REQ-031 Reset deassertion mid-operation SHALL require no flush; first edge after release operates normally.

Structure
REQ-032 Shared package pipe_regfile_pkg SHALL hold default XLEN/NREG constants and a reg-address typedef.
REQ-033 Write-port priority resolution (per-address winning port and data) SHALL be one sub-module, regfile_wr_arb.

Verification
REQ-034 Reset, then read addresses 0..31 -> all rd_data=0, busy_vec=0.
REQ-035 Write port0 addr 5 = 0xDEADBEEF, same cycle read addr 5 -> BYPASS=1 gives 0xDEADBEEF that cycle; BYPASS=0 gives 0 then 0xDEADBEEF next cycle.
REQ-036 Port0 and port1 both write addr 7 (0x11, 0x22) -> addr 7 reads 0x22 afterwards.
REQ-037 Write addr 0 = 0xFFFFFFFF, alloc addr 0 -> rd_data 0, busy_vec[0]=0.
REQ-038 Alloc addr 3, next cycle alloc addr 3 plus write addr 3 = 0x5 -> busy_vec[3]=1, reads 0x5; flush next cycle -> busy_vec=0.
REQ-039 Assert rst_n low between edges after writing addr 9 = 0x1234 -> rd_data immediately 0, busy cleared without a clock edge.

Source files
------------

// File: rtl/pipe_regfile_pkg.sv
// Shared constants and types for the pipelined register file.
package pipe_regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

  // Register-index type for the default geometry.
  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage : pipe_regfile_pkg

// File: rtl/pipe_regfile_wr_arb.sv
// Write-port priority resolution: for every register, whether any port writes
// it this cycle and which data wins (highest port index). Register 0 is never hit.
module regfile_wr_arb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NWR  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic [NWR-1:0]           i_wr_en,
  input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] i_wr_data,
  output logic [NREG-1:0]          o_hit,
  output logic [XLEN-1:0]          o_data [NREG]
);

  // Ascending port scan: a later (higher) port overwrites an earlier one.
  always_comb begin
    o_hit = '0;
    for (int unsigned a = 0; a < NREG; a++) o_data[a] = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (i_wr_en[p] && (i_wr_addr[p] != '0)) begin
        o_hit[i_wr_addr[p]]  = 1'b1;
        o_data[i_wr_addr[p]] = i_wr_data[p];
      end
    end
  end

endmodule : regfile_wr_arb

// File: rtl/pipe_regfile.sv
// Multi-ported register file with optional write-to-read bypass and a
// busy-bit scoreboard tracking pending writes. Register 0 is hardwired to 0.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  input  logic                     flush,
  output logic [NREG-1:0]          busy_vec
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_hit;
  logic [XLEN-1:0] w_wdata [NREG];

  regfile_wr_arb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_wr_arb (
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_hit     (w_hit),
    .o_data    (w_wdata)
  );

  // Register storage: commit the winning write data of each hit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < NREG; a++) r_regs[a] <= '0;
    end else begin
      for (int unsigned a = 1; a < NREG; a++) begin
        if (w_hit[a]) r_regs[a] <= w_wdata[a];
      end
    end
  end

  // Scoreboard: writes clear, alloc sets afterwards so a new producer wins;
  // flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= r_busy & ~w_hit;
      if (alloc_en && (alloc_addr != '0)) r_busy[alloc_addr] <= 1'b1;
    end
  end

  assign busy_vec = r_busy;

  // Read ports: stored value or forwarded write data; forced to 0 in reset so
  // bypassed writes cannot leak while rst_n is low.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned r = 0; r < NRD; r++) begin
      if (rst_n) begin
        if ((BYPASS != 0) && w_hit[rd_addr[r]]) begin
          rd_data[r] = w_wdata[rd_addr[r]];
          rd_busy[r] = 1'b0;
        end else begin
          rd_data[r] = r_regs[rd_addr[r]];
          rd_busy[r] = r_busy[rd_addr[r]];
        end
      end
    end
  end

endmodule : pipe_regfile

// File: tb/tb_pipe_regfile.sv
// Directed bench: a bypassing and a non-bypassing instance share all inputs.
module tb_pipe_regfile;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data_b, rd_data_n;
  logic [1:0]       rd_busy_b, rd_busy_n;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             alloc_en;
  logic [4:0]       alloc_addr;
  logic             flush;
  logic [31:0]      busy_b, busy_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_regfile #(.BYPASS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_b)
  );

  pipe_regfile #(.BYPASS(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_n)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    flush      = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]   = 1'b1;
    wr_addr[p] = a;
    wr_data[p] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    repeat (2) @(negedge clk);

    // Reset state: every address reads 0, nothing busy.
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      rd_addr[1] = 5'(31 - a);
      #1;
      chk("rst_rd_b0", rd_data_b[0], 0);
      chk("rst_rd_n1", rd_data_n[1], 0);
    end
    chk("rst_busy_b", busy_b, 0);
    chk("rst_busy_n", busy_n, 0);
    @(negedge clk); rst_n = 1'b1;

    // Same-cycle write/read of addr 5.
    @(negedge clk); wr(0, 5'd5, 32'hDEADBEEF); rd_addr[0] = 5'd5; #1;
    chk("byp_same_b", rd_data_b[0], 32'hDEADBEEF);
    chk("byp_same_n", rd_data_n[0], 0);
    @(negedge clk); idle(); #1;
    chk("byp_next_b", rd_data_b[0], 32'hDEADBEEF);
    chk("byp_next_n", rd_data_n[0], 32'hDEADBEEF);

    // Two ports write addr 7: port 1 wins.
    @(negedge clk); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd7; #1;
    chk("prio_same_b", rd_data_b[1], 32'h22);
    @(negedge clk); idle(); #1;
    chk("prio_b0", rd_data_b[0], 32'h22);
    chk("prio_n1", rd_data_n[1], 32'h22);

    // Register 0: writes and allocs ignored.
    @(negedge clk); wr(1, 5'd0, 32'hFFFFFFFF); alloc_en = 1'b1; alloc_addr = 5'd0;
    rd_addr[0] = 5'd0; #1;
    chk("r0_same_b", rd_data_b[0], 0);
    @(negedge clk); idle(); #1;
    chk("r0_rd_b", rd_data_b[0], 0);
    chk("r0_rd_n", rd_data_n[0], 0);
    chk("r0_busy", busy_b, 0);

    // Alloc 3, then alloc + write 3, then flush (with alloc 4 and write 10).
    @(negedge clk); alloc_en = 1'b1; alloc_addr = 5'd3;
    @(negedge clk); idle(); rd_addr[0] = 5'd3; #1;
    chk("alloc_vec", busy_b, 32'h8);
    chk("alloc_rdbusy", rd_busy_b[0], 1);
    alloc_en = 1'b1; alloc_addr = 5'd3; wr(0, 5'd3, 32'h5); #1;
    chk("aw_rdbusy_b", rd_busy_b[0], 0);
    chk("aw_rdbusy_n", rd_busy_n[0], 1);
    chk("aw_rd_b", rd_data_b[0], 32'h5);
    chk("aw_rd_n", rd_data_n[0], 0);
    @(negedge clk); idle(); #1;
    chk("aw_vec_b", busy_b, 32'h8);
    chk("aw_vec_n", busy_n, 32'h8);
    chk("aw_rd3", rd_data_n[0], 32'h5);
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd4; wr(1, 5'd10, 32'hAA);
    @(negedge clk); idle(); rd_addr[1] = 5'd10; #1;
    chk("flush_vec", busy_b, 0);
    chk("flush_data3", rd_data_n[0], 32'h5);
    chk("flush_wr10", rd_data_n[1], 32'hAA);

    // Write-only clears busy; top address 31 usable.
    @(negedge clk); alloc_en = 1'b1; alloc_addr = 5'd31;
    @(negedge clk); idle(); rd_addr[0] = 5'd31; #1;
    chk("busy31", busy_n, 32'h8000_0000);
    wr(1, 5'd31, 32'hCAFE0031);
    @(negedge clk); idle(); #1;
    chk("clr31", busy_n, 0);
    chk("rd31", rd_data_b[0], 32'hCAFE0031);

    // Asynchronous reset mid-cycle.
    @(negedge clk); wr(0, 5'd9, 32'h1234); alloc_en = 1'b1; alloc_addr = 5'd9;
    @(negedge clk); idle(); rd_addr[0] = 5'd9; rd_addr[1] = 5'd12; #1;
    chk("pre_rst_rd9", rd_data_n[0], 32'h1234);
    chk("pre_rst_busy", busy_b, 32'h200);
    #2; rst_n = 1'b0; wr(0, 5'd12, 32'h77); #1;
    chk("arst_rd9", rd_data_b[0], 0);
    chk("arst_busy", busy_b, 0);
    chk("arst_byp12", rd_data_b[1], 0);
    @(negedge clk); idle();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); wr(0, 5'd12, 32'h77);
    @(negedge clk); idle(); #1;
    chk("post_rd9", rd_data_n[0], 0);
    chk("post_rd12", rd_data_n[1], 32'h77);
    chk("post_busy", busy_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipe_regfile
